// File: rtl/mem_access_pkg.sv
// Shared state encoding and parameter defaults for the memory access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        MERGE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int LAT_DEFAULT       = 2;
    localparam int MEM_WORDS_DEFAULT = 1024;

endpackage

// File: rtl/mem_sram.sv
// Word-wide storage: combinational read, synchronous single-port write, contents survive reset.
module mem_sram #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk_sys,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk_sys) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit with fixed access latency, byte read-modify-write and error reporting.
//
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | latency countdown; word stores commit on exit
//   MERGE | byte store read-modify-write
//   RESP  | one-cycle completion pulse
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int LAT       = LAT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_valid,
    input  logic        Req_we,
    input  logic        Req_byte,
    input  logic [31:0] Req_addr,
    input  logic [31:0] Req_wdata,
    output logic        Req_ready,
    output logic        Rsp_valid,
    output logic [31:0] Rsp_rdata,
    output logic        Rsp_err
);

    localparam int AW = $clog2(MEM_WORDS);

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic        byte_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   mem_rdata;
    logic [31:0]   mem_wdata;
    logic [31:0]   merged;
    logic [7:0]    lane_byte;
    logic          mem_we;
    logic          addr_err;
    logic          wait_done;

    assign idx       = addr_q[AW+1:2];
    assign lane      = addr_q[1:0];
    // Upper address bits must be zero: addresses beyond storage never alias.
    assign addr_err  = (addr_q[31:AW+2] != '0) || (!byte_q && (lane != 2'd0));
    assign wait_done = (state == WAIT) && (cnt == 4'd0);

    always_comb begin
        merged    = mem_rdata;
        lane_byte = mem_rdata[7:0];
        case (lane)
            2'd0: begin lane_byte = mem_rdata[7:0];   merged[7:0]   = wdata_q[7:0]; end
            2'd1: begin lane_byte = mem_rdata[15:8];  merged[15:8]  = wdata_q[7:0]; end
            2'd2: begin lane_byte = mem_rdata[23:16]; merged[23:16] = wdata_q[7:0]; end
            default: begin lane_byte = mem_rdata[31:24]; merged[31:24] = wdata_q[7:0]; end
        endcase
    end

    // Gating with Reset keeps an aborted request from committing if reset spans an edge.
    assign mem_we    = !Reset &&
                       ((wait_done && we_q && !byte_q && !addr_err) || (state == MERGE));
    assign mem_wdata = (state == MERGE) ? merged : wdata_q;

    mem_sram #(
        .WORDS (MEM_WORDS)
    ) u_sram (
        .clk_sys (Clk),
        .we      (mem_we),
        .addr    (idx),
        .wdata   (mem_wdata),
        .rdata   (mem_rdata)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            Req_ready <= 1'b1;
            Rsp_valid <= 1'b0;
            Rsp_rdata <= '0;
            Rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Req_valid) begin
                        we_q      <= Req_we;
                        byte_q    <= Req_byte;
                        addr_q    <= Req_addr;
                        wdata_q   <= Req_wdata;
                        cnt       <= 4'(LAT - 1);
                        Req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (we_q && byte_q && !addr_err) begin
                        state <= MERGE;
                    end else begin
                        state     <= RESP;
                        Rsp_valid <= 1'b1;
                        Rsp_err   <= addr_err;
                        if (we_q || addr_err) begin
                            Rsp_rdata <= '0;
                        end else if (byte_q) begin
                            Rsp_rdata <= {24'd0, lane_byte};
                        end else begin
                            Rsp_rdata <= mem_rdata;
                        end
                    end
                end
                MERGE: begin
                    state     <= RESP;
                    Rsp_valid <= 1'b1;
                    Rsp_err   <= 1'b0;
                    Rsp_rdata <= '0;
                end
                RESP: begin
                    state     <= IDLE;
                    Req_ready <= 1'b1;
                    Rsp_valid <= 1'b0;
                    Rsp_rdata <= '0;
                    Rsp_err   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    Req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized checks of mem_access_unit against a word-array reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int LAT       = 2;
    localparam int MEM_WORDS = 1024;

    logic        Clk;
    logic        Reset;
    logic        Req_valid;
    logic        Req_we;
    logic        Req_byte;
    logic [31:0] Req_addr;
    logic [31:0] Req_wdata;
    logic        Req_ready;
    logic        Rsp_valid;
    logic [31:0] Rsp_rdata;
    logic        Rsp_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model_mem [MEM_WORDS];

    mem_access_unit #(
        .MEM_WORDS (MEM_WORDS),
        .LAT       (LAT)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req_valid (Req_valid),
        .Req_we    (Req_we),
        .Req_byte  (Req_byte),
        .Req_addr  (Req_addr),
        .Req_wdata (Req_wdata),
        .Req_ready (Req_ready),
        .Rsp_valid (Rsp_valid),
        .Rsp_rdata (Rsp_rdata),
        .Rsp_err   (Rsp_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_noise();
        Req_valid = 1'b1;
        Req_we    = 1'($urandom);
        Req_byte  = 1'($urandom);
        Req_addr  = $urandom;
        Req_wdata = $urandom;
    endtask

    // Called just after a negedge with the DUT idle; returns just after a negedge with the DUT idle.
    task automatic do_req(input bit we, input bit bt, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit noise, input string tag,
                          output logic [31:0] got_rdata);
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] old_word;
        int          w;
        int          sh;
        int          exp_lat;
        int          lat;
        bit          got;

        exp_err   = (addr >= 32'(4 * MEM_WORDS)) || (!bt && (addr % 4 != 0));
        w         = int'(addr / 4);
        sh        = 8 * int'(addr % 4);
        old_word  = exp_err ? 32'd0 : model_mem[w];
        if (exp_err || we)  exp_rdata = 32'd0;
        else if (bt)        exp_rdata = (old_word >> sh) & 32'hFF;
        else                exp_rdata = old_word;
        exp_lat = (we && bt && !exp_err) ? LAT + 2 : LAT + 1;

        Req_valid = 1'b1;
        Req_we    = we;
        Req_byte  = bt;
        Req_addr  = addr;
        Req_wdata = wdata;
        check({tag, " ready_before"}, 32'(Req_ready), 32'd1);
        @(posedge Clk);

        lat = 0;
        got = 0;
        while (!got && lat < 32) begin
            @(negedge Clk);
            lat++;
            if (Rsp_valid === 1'b1) begin
                got = 1;
            end else if (noise) begin
                drive_noise();
            end else begin
                Req_valid = 1'b0;
            end
        end
        Req_valid = 1'b0;
        got_rdata = Rsp_rdata;
        check({tag, " latency"}, 32'(lat), got ? 32'(exp_lat) : 32'hFFFF_FFFF);
        check({tag, " ready_busy"}, 32'(Req_ready), 32'd0);
        check({tag, " rdata"}, Rsp_rdata, exp_rdata);
        check({tag, " err"}, 32'(Rsp_err), 32'(exp_err));

        if (we && !exp_err) begin
            if (bt) model_mem[w] = (old_word & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
            else    model_mem[w] = wdata;
        end

        @(negedge Clk);
        check({tag, " pulse_end"}, 32'(Rsp_valid), 32'd0);
        check({tag, " ready_after"}, 32'(Req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          lat;
        bit          got;
        int          sel;

        Reset     = 1'b1;
        Req_valid = 1'b0;
        Req_we    = 1'b0;
        Req_byte  = 1'b0;
        Req_addr  = '0;
        Req_wdata = '0;
        repeat (2) @(negedge Clk);
        check("reset ready", 32'(Req_ready), 32'd1);
        check("reset valid", 32'(Rsp_valid), 32'd0);
        check("reset rdata", Rsp_rdata, 32'd0);
        check("reset err", 32'(Rsp_err), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 16; i++) begin
            do_req(1, 0, 32'(4 * i), $urandom, 0, "init_sw", rd);
        end

        do_req(1, 0, 32'h10, 32'hDEADBEEF, 0, "sw_10", rd);
        do_req(0, 0, 32'h10, 32'h0, 0, "lw_10", rd);
        check("lw_10 const", rd, 32'hDEADBEEF);
        do_req(1, 1, 32'h12, 32'h000000A5, 0, "sb_12", rd);
        do_req(0, 0, 32'h10, 32'h0, 0, "lw_10_merged", rd);
        check("lw_10_merged const", rd, 32'hDEA5BEEF);
        do_req(0, 1, 32'h13, 32'h0, 0, "lb_13", rd);
        check("lb_13 const", rd, 32'h000000DE);

        do_req(0, 0, 32'h11, 32'h0, 0, "lw_misaligned", rd);
        do_req(1, 0, 32'h1000, 32'hCAFEF00D, 0, "sw_oob", rd);
        do_req(0, 0, 32'h0, 32'h0, 0, "lw_0_unchanged", rd);
        do_req(1, 1, 32'hFFFF_FFFF, 32'h77, 0, "sb_oob", rd);
        do_req(0, 1, 32'h1000, 32'h0, 0, "lb_oob", rd);
        do_req(0, 0, 32'hFFC, 32'h0, 0, "lw_last_unset_err0", rd);

        // Reset pulse while the word store waits: nothing may commit.
        Req_valid = 1'b1; Req_we = 1'b1; Req_byte = 1'b0;
        Req_addr  = 32'h20; Req_wdata = 32'h12345678;
        @(posedge Clk);
        #1 Req_valid = 1'b0;
        #2 Reset = 1'b1;
        #0.2 check("abort_wait ready_in_reset", 32'(Req_ready), 32'd1);
        #0.3 Reset = 1'b0;
        check("abort_wait ready_after", 32'(Req_ready), 32'd1);
        got = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge Clk);
            if (Rsp_valid === 1'b1) got = 1;
        end
        check("abort_wait no_rsp", 32'(got), 32'd0);
        do_req(0, 0, 32'h20, 32'h0, 0, "lw_20_prior", rd);

        // Reset pulse during the byte-store merge cycle.
        Req_valid = 1'b1; Req_we = 1'b1; Req_byte = 1'b1;
        Req_addr  = 32'h25; Req_wdata = 32'h000000C3;
        @(posedge Clk);
        #1 Req_valid = 1'b0;
        repeat (LAT) @(posedge Clk);
        #3 Reset = 1'b1;
        #0.5 Reset = 1'b0;
        got = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge Clk);
            if (Rsp_valid === 1'b1) got = 1;
        end
        check("abort_merge no_rsp", 32'(got), 32'd0);
        do_req(0, 0, 32'h24, 32'h0, 0, "lw_24_prior", rd);

        // Back-to-back loads with Req_valid held high throughout.
        Req_valid = 1'b1; Req_we = 1'b0; Req_byte = 1'b0; Req_addr = 32'h8;
        @(posedge Clk);
        for (int k = 0; k < 2; k++) begin
            lat = 0;
            got = 0;
            while (!got && lat < 32) begin
                @(negedge Clk);
                lat++;
                check("b2b ready_low", 32'(Req_ready), 32'd0);
                if (Rsp_valid === 1'b1) got = 1;
            end
            check("b2b latency", 32'(lat), got ? 32'(LAT + 1) : 32'hFFFF_FFFF);
            check("b2b rdata", Rsp_rdata, (k == 0) ? model_mem[2] : model_mem[3]);
            @(negedge Clk);
            check("b2b idle_valid", 32'(Rsp_valid), 32'd0);
            check("b2b idle_ready", 32'(Req_ready), 32'd1);
            if (k == 0) begin
                Req_addr = 32'hC;
                @(posedge Clk);
            end else begin
                Req_valid = 1'b0;
            end
        end
        @(negedge Clk);

        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) a = 32'(4 * MEM_WORDS) + ($urandom & 32'h0FFF_FFFF);
            else          a = $urandom_range(0, 63);
            do_req(1'($urandom), 1'($urandom), a, $urandom, 1'($urandom), "rand", rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
